serial_word_tx: RTL

- Parallel-to-serial transmitter directly upstream of the 4-bit serial-in/parallel-load shift register.
- Accepts NBITS-bit words over a valid/ready handshake, keeps one word pending, and shifts each word out LSB-first on serial_out.
- After NBITS shifts, the downstream register (which shifts into its MSB toward bit 0) holds the word unchanged.
- Runs on the same slow board clock; reset is driven from a switch.

---
 rtl/serial_word_tx.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/serial_word_tx.sv
// serial_word_tx
// Parallel-to-serial transmitter that feeds a serial-in/parallel-load shift
// register. Words arrive over a load/ready handshake and leave LSB-first on
// serial_out. The register downstream shifts into its MSB, so after NBITS
// shifts it holds the word unchanged. One further word can be held pending
// while a frame is on the wire.
//
// Optional feature: define SERIAL_TX_PARITY_EN to append one even-parity bit
// period (XOR of the data bits) after the data bits of every frame.
//
// Ports:
//   clk_2       in   board clock, rising-edge active
//   reset       in   asynchronous, active-high reset
//   data_in     in   [NBITS] word to transmit
//   load        in   word valid; accepted on a rising edge where load && ready
//   ready       out  pending slot empty (combinational)
//   serial_out  out  current serial bit, 0 when not shifting
//   bit_valid   out  serial_out carries a data/parity bit (downstream shift enable)
//   busy        out  any state other than IDLE
//   frame_done  out  pulse in the final cycle of a frame's last bit period
//   frame_count out  [8] completed frames, wraps 255 -> 0
module serial_word_tx #(
  parameter int NBITS      = 4,
  parameter int BIT_CYCLES = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [NBITS-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       frame_count
);

  localparam int IW   = $clog2(NBITS);
  localparam int CMAX = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(NBITS - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_GAP    = 2'd3
  } state_t;

`ifdef SERIAL_TX_PARITY_EN
  function automatic logic even_parity(input logic [NBITS-1:0] word);
    return ^word;
  endfunction
`endif

  state_t           state_r, state_s;
  logic [NBITS-1:0] shifter_r, shifter_s;
  logic [NBITS-1:0] pending_r, pending_s;
  logic             pend_full_r, pend_full_s;
  logic [IW-1:0]    bit_idx_r, bit_idx_s;
  logic [CW-1:0]    cyc_r, cyc_s;
  logic [7:0]       count_r, count_s;
  logic             accept_s;
  logic             data_done_s;
  logic             enter_next_s;

  assign ready       = ~pend_full_r;
  assign busy        = (state_r != S_IDLE);
  assign frame_count = count_r;

  // Next-state, datapath and output decode
  always_comb begin
    state_s      = state_r;
    shifter_s    = shifter_r;
    pending_s    = pending_r;
    pend_full_s  = pend_full_r;
    bit_idx_s    = bit_idx_r;
    cyc_s        = cyc_r;
    count_s      = count_r;
    serial_out   = 1'b0;
    bit_valid    = 1'b0;
    frame_done   = 1'b0;
    data_done_s  = 1'b0;
    enter_next_s = 1'b0;
    accept_s     = load & ~pend_full_r;

    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          shifter_s = data_in;
          bit_idx_s = '0;
          cyc_s     = '0;
          state_s   = S_SHIFT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SHIFT: begin
        serial_out = shifter_r[bit_idx_r];
        bit_valid  = 1'b1;
        if (cyc_r == BIT_LAST) begin
          cyc_s = '0;
          if (bit_idx_r == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
            state_s = S_PARITY;
`else
            frame_done  = 1'b1;
            data_done_s = 1'b1;
`endif
          end else begin
            bit_idx_s = bit_idx_r + IW'(1);
          end
        end else begin
          cyc_s = cyc_r + CW'(1);
        end
      end
      S_PARITY: begin
`ifdef SERIAL_TX_PARITY_EN
        serial_out = even_parity(shifter_r);
`else
        serial_out = 1'b0;
`endif
        bit_valid = 1'b1;
        if (cyc_r == BIT_LAST) begin
          cyc_s       = '0;
          frame_done  = 1'b1;
          data_done_s = 1'b1;
        end else begin
          cyc_s = cyc_r + CW'(1);
        end
      end
      S_GAP: begin
        if (cyc_r == GAP_LAST) begin
          enter_next_s = 1'b1;
        end else begin
          cyc_s = cyc_r + CW'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    // Frame body finished: idle gap, or straight to the decision point
    if (data_done_s) begin
      if (GAP_CYCLES > 0) begin
        state_s = S_GAP;
        cyc_s   = '0;
      end else begin
        enter_next_s = 1'b1;
      end
    end else begin
      enter_next_s = enter_next_s;
    end

    // Zero-time decision between frames. An accept landing on this very edge
    // goes straight into the shifter; writing it to the pending slot while
    // returning to IDLE would strand it there.
    if (enter_next_s) begin
      bit_idx_s = '0;
      cyc_s     = '0;
      if (pend_full_r) begin
        shifter_s   = pending_r;
        pend_full_s = 1'b0;
        state_s     = S_SHIFT;
      end else if (accept_s) begin
        shifter_s = data_in;
        state_s   = S_SHIFT;
      end else begin
        state_s = S_IDLE;
      end
    end else if (accept_s && (state_r != S_IDLE)) begin
      pending_s   = data_in;
      pend_full_s = 1'b1;
    end else begin
      pend_full_s = pend_full_s;
    end

    if (frame_done) begin
      count_s = count_r + 8'd1;
    end else begin
      count_s = count_r;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      shifter_r   <= '0;
      pending_r   <= '0;
      pend_full_r <= 1'b0;
      bit_idx_r   <= '0;
      cyc_r       <= '0;
      count_r     <= 8'd0;
    end else begin
      state_r     <= state_s;
      shifter_r   <= shifter_s;
      pending_r   <= pending_s;
      pend_full_r <= pend_full_s;
      bit_idx_r   <= bit_idx_s;
      cyc_r       <= cyc_s;
      count_r     <= count_s;
    end
  end

endmodule
